inference_seq_argmax: RTL and testbench

//  Sequencer and classifier for the dnn_relu_fix12 inference engine.
//  - Takes a host request and pulses the engine's soft reset, then its start.
//  - Waits for engine done, then scans the 10 class scores over out_idx.
//  - Resolves the signed argmax and returns digit + score on a valid/ack handshake.
//  - Sits between the host/testbench and the top_relu_fix12 wrapper; weight memory stays on the engine side.

---
 rtl/inference_seq_argmax_if.sv | 44 ++++
 rtl/inference_seq_argmax.sv | 164 ++++++++++++++++
 tb/tb_inference_seq_argmax.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inference_seq_argmax_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : inference_seq_argmax_if
// Description : Bundle of the host result handshake and the engine control /
//               score-select signals used by inference_seq_argmax.
//               master : the sequencer (drives busy/result/engine controls)
//               slave  : host + engine side (drives req/ack/done/score)
// Signals     : req, busy, res_valid, res_ack, res_class, res_score, res_err,
//               eng_reset, eng_start, eng_done, eng_idx, eng_out
// Revision    : 1.0 - initial release
// ============================================================================
interface inference_seq_argmax_if #(
    parameter int DATA_WIDTH = 12,
    parameter int IDX_WIDTH  = 4
);
    // Host side
    logic                         req;
    logic                         busy;
    logic                         res_valid;
    logic                         res_ack;
    logic [IDX_WIDTH-1:0]         res_class;
    logic signed [DATA_WIDTH-1:0] res_score;
    logic                         res_err;
    // Engine side
    logic                         eng_reset;
    logic                         eng_start;
    logic                         eng_done;
    logic [IDX_WIDTH-1:0]         eng_idx;
    logic signed [DATA_WIDTH-1:0] eng_out;

    modport master (
        input  req, res_ack, eng_done, eng_out,
        output busy, res_valid, res_class, res_score, res_err,
               eng_reset, eng_start, eng_idx
    );

    modport slave (
        output req, res_ack, eng_done, eng_out,
        input  busy, res_valid, res_class, res_score, res_err,
               eng_reset, eng_start, eng_idx
    );
endinterface
`default_nettype wire

// File: rtl/inference_seq_argmax.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : inference_seq_argmax
// Description : Sequencer + argmax classifier for the fix12 inference engine.
//               On a host request it pulses the engine soft reset, then start,
//               waits for engine done, scans NUM_CLASSES signed scores one per
//               cycle and presents the winning class/score on a valid/ack
//               handshake.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous reset, active low
//               bus   - inference_seq_argmax_if.master (host + engine signals)
// Options     : ARGMAX_TIMEOUT_EN - when defined, a watchdog aborts WAIT after
//               TIMEOUT_CYCLES cycles and returns a result with res_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module inference_seq_argmax #(
    parameter int DATA_WIDTH     = 12,
    parameter int NUM_CLASSES    = 10,
    parameter int IDX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inference_seq_argmax_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_SCAN   = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    localparam logic [IDX_WIDTH-1:0] C_LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    logic [2:0]                   state_q, state_d;
    logic [IDX_WIDTH-1:0]         idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic [IDX_WIDTH-1:0]         arg_q, arg_d;
    logic                         scan_last;

`ifdef ARGMAX_TIMEOUT_EN
    // One spare bit so the count can never wrap before the limit is seen.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    assign timeout_hit = (cnt_q == C_CNT_LAST);
`endif

    assign scan_last = (idx_q == C_LAST_IDX);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            max_q   <= '0;
            arg_q   <= '0;
`ifdef ARGMAX_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            arg_q   <= arg_d;
`ifdef ARGMAX_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.req) state_d = S_CLR;
            S_CLR:    state_d = S_START;
            S_START:  state_d = S_WAIT;
            // eng_done is only trusted here: the CLR pulse has flushed any
            // done level left over from a previous inference.
            S_WAIT: begin
                if (bus.eng_done) begin
                    state_d = S_SCAN;
                end
`ifdef ARGMAX_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = S_RESULT;
                end
`endif
            end
            S_SCAN:   if (scan_last) state_d = S_RESULT;
            S_RESULT: if (bus.res_ack) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: scan index, running max, watchdog
    // ------------------------------------------------------------------
    always_comb begin
        idx_d = idx_q;
        max_d = max_q;
        arg_d = arg_q;
`ifdef ARGMAX_TIMEOUT_EN
        cnt_d = cnt_q;
        err_d = err_q;
`endif
        case (state_q)
`ifdef ARGMAX_TIMEOUT_EN
            S_CLR:   err_d = 1'b0;
            S_START: cnt_d = '0;
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!bus.eng_done && timeout_hit) begin
                    err_d = 1'b1;
                    arg_d = '0;
                    max_d = '0;
                end
            end
`endif
            S_SCAN: begin
                // Index 0 seeds the max; strict '>' keeps the lower index on ties.
                if ((idx_q == '0) || (bus.eng_out > max_q)) begin
                    max_d = bus.eng_out;
                    arg_d = idx_q;
                end
                idx_d = scan_last ? '0 : idx_q + IDX_WIDTH'(1);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (Moore, decoded from state)
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.eng_reset = (state_q == S_CLR);
        bus.eng_start = (state_q == S_START);
        bus.res_valid = (state_q == S_RESULT);
        bus.eng_idx   = idx_q;
        bus.res_class = arg_q;
        bus.res_score = max_q;
`ifdef ARGMAX_TIMEOUT_EN
        bus.res_err   = err_q;
`else
        bus.res_err   = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_inference_seq_argmax.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_inference_seq_argmax
// Description : Self-checking bench for inference_seq_argmax. A timestamp
//               based reference model predicts every output each cycle; an
//               engine model serves scores from a table. Directed scenarios
//               plus randomized transactions. Honours ARGMAX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inference_seq_argmax;

    localparam int NC = 10;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n;

    inference_seq_argmax_if #(.DATA_WIDTH(12), .IDX_WIDTH(4)) bus ();

    inference_seq_argmax #(.DATA_WIDTH(12), .NUM_CLASSES(NC), .IDX_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Engine model: score table selected combinationally by eng_idx.
    logic signed [11:0] sc [NC];
    assign bus.eng_out = (bus.eng_idx < 4'(NC)) ? sc[bus.eng_idx] : 12'sd0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Argmax from the rules: first index holding the largest signed value.
    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < NC; i++)
            if (int'(sc[i]) > int'(sc[best])) best = i;
        return best;
    endfunction

    // ------------------------------------------------------------------
    // Reference model + per-cycle compare (sampled on falling edge)
    // ------------------------------------------------------------------
    bit m_act;
    int m_t0, m_d, m_rv;
    int m_cls, m_scr, m_err;
    int m_lcls, m_lscr, m_lerr;
    bit w_scan, w_rv;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_act = 1'b0; m_t0 = 0; m_d = -1; m_rv = -1;
            m_lcls = 0; m_lscr = 0; m_lerr = 0;
            chk("rst_busy",      bus.busy,      0);
            chk("rst_eng_reset", bus.eng_reset, 0);
            chk("rst_eng_start", bus.eng_start, 0);
            chk("rst_eng_idx",   bus.eng_idx,   0);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_res_class", bus.res_class, 0);
            chk("rst_res_score", bus.res_score, 0);
            chk("rst_res_err",   bus.res_err,   0);
        end else begin
            w_scan = m_act && (m_d >= 0) && (cyc >= m_d + 1) && (cyc <= m_d + NC);
            w_rv   = m_act && (m_rv >= 0) && (cyc >= m_rv);
            if (w_rv && cyc == m_rv) begin
                m_lcls = m_cls; m_lscr = m_scr; m_lerr = m_err;
            end
            chk("busy",      bus.busy,      int'(m_act));
            chk("eng_reset", bus.eng_reset, int'(m_act && cyc == m_t0 + 1));
            chk("eng_start", bus.eng_start, int'(m_act && cyc == m_t0 + 2));
            chk("eng_idx",   bus.eng_idx,   w_scan ? cyc - m_d - 1 : 0);
            chk("res_valid", bus.res_valid, int'(w_rv));
            if (!w_scan) begin
                chk("res_class", bus.res_class, m_lcls);
                chk("res_score", bus.res_score, m_lscr);
            end
            if (w_rv) chk("res_err", bus.res_err, m_lerr);

            // Advance the model with the inputs the coming edge will see.
            if (!m_act) begin
                if (bus.req) begin
                    m_act = 1'b1; m_t0 = cyc; m_d = -1; m_rv = -1;
                end
            end else if (w_rv) begin
                if (bus.res_ack) m_act = 1'b0;
            end else if (m_d < 0 && m_rv < 0 && cyc >= m_t0 + 3) begin
                if (bus.eng_done) begin
                    m_d   = cyc;
                    m_rv  = cyc + NC + 1;
                    m_cls = ref_argmax();
                    m_scr = int'(sc[m_cls]);
                    m_err = 0;
                end
`ifdef ARGMAX_TIMEOUT_EN
                else if (cyc - (m_t0 + 3) == TO - 1) begin
                    m_rv = cyc + 1; m_cls = 0; m_scr = 0; m_err = 1;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic do_req(output int t0);
        @(posedge clk); #1 bus.req = 1'b1; t0 = cyc;
        @(posedge clk); #1 bus.req = 1'b0;
    endtask

    task automatic set_done_after(input int k, output int dc);
        repeat (k) @(posedge clk);
        #1 bus.eng_done = 1'b1; dc = cyc;
    endtask

    task automatic wait_valid(output int vc);
        vc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin vc = cyc; break; end
        end
        if (vc < 0) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic ack_after(input int k, input bit clr_done);
        repeat (k + 1) @(posedge clk);
        #1 bus.res_ack = 1'b1;
        @(posedge clk);
        #1 bus.res_ack = 1'b0;
        if (clr_done) bus.eng_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_watchdog: actual running required finished");
        $fatal(1);
    end

    initial begin
        int t0, dc, vc, ta, cr;
        int lit [NC] = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 99};
        bus.req = 1'b0; bus.res_ack = 1'b0; bus.eng_done = 1'b0;
        for (int i = 0; i < NC; i++) sc[i] = 12'(lit[i]);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Scenario 1: basic argmax, done 20 cycles after start.
        chk("t1_model_pin", ref_argmax(), 2);
        do_req(t0);
        set_done_after(21, dc);
        wait_valid(vc);
        chk("t1_class",   bus.res_class, 2);
        chk("t1_score",   bus.res_score, 100);
        chk("t1_latency", vc - dc, 11);
        ack_after(0, 1'b0);               // leave eng_done high (stale)

        // Scenario 3: pulses with a stale done level held through CLR/START.
        do_req(t0);
        @(negedge clk);
        chk("t3_clr_reset", bus.eng_reset, 1);
        chk("t3_clr_start", bus.eng_start, 0);
        @(negedge clk);
        chk("t3_start_reset", bus.eng_reset, 0);
        chk("t3_start_start", bus.eng_start, 1);
        @(negedge clk);
        chk("t3_wait_start", bus.eng_start, 0);
        chk("t3_wait_busy",  bus.busy, 1);
        wait_valid(vc);
        chk("t3_class", bus.res_class, 2);

        // Scenario 4: slow ack with req held for a back-to-back request.
        @(posedge clk); #1 bus.req = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("t4_hold_valid", bus.res_valid, 1);
        chk("t4_hold_class", bus.res_class, 2);
        chk("t4_hold_score", bus.res_score, 100);
        bus.res_ack = 1'b1; ta = cyc;
        @(posedge clk); #1 bus.res_ack = 1'b0;
        cr = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.eng_reset) begin cr = cyc; break; end
        end
        chk("t4_b2b_reset", cr - ta, 2);
        @(posedge clk); #1 bus.req = 1'b0;

        // Scenario 5: asynchronous reset in the middle of SCAN (idx 4).
        cr = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.eng_idx == 4'd4) begin cr = cyc; break; end
        end
        chk("t5_reach_idx4", int'(cr >= 0), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy",  bus.busy, 0);
        chk("t5_idx",   bus.eng_idx, 0);
        chk("t5_valid", bus.res_valid, 0);
        chk("t5_class", bus.res_class, 0);
        chk("t5_score", bus.res_score, 0);
        bus.eng_done = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NC; i++) sc[i] = 12'($urandom_range(0, 4095));
        do_req(t0);
        set_done_after(5, dc);
        wait_valid(vc);
        chk("t5_fresh_latency", vc - dc, 11);
        chk("t5_fresh_class", bus.res_class, ref_argmax());
        ack_after(2, 1'b1);

        // Scenario 2: all-equal tie, then max at the last index.
        for (int i = 0; i < NC; i++) sc[i] = -12'sd50;
        chk("t2_model_tie", ref_argmax(), 0);
        do_req(t0);
        set_done_after(3, dc);
        wait_valid(vc);
        chk("t2_tie_class", bus.res_class, 0);
        chk("t2_tie_score", bus.res_score, -50);
        ack_after(1, 1'b1);
        for (int i = 0; i < NC; i++) sc[i] = -12'sd2048;
        sc[9] = 12'sd2047;
        do_req(t0);
        set_done_after(2, dc);
        wait_valid(vc);
        chk("t2_last_class", bus.res_class, 9);
        chk("t2_last_score", bus.res_score, 2047);
        ack_after(0, 1'b1);

        // Randomized transactions (narrow ranges force ties).
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NC; i++)
                sc[i] = (n % 2 == 0) ? 12'($urandom_range(0, 6)) - 12'sd3
                                     : 12'($urandom_range(0, 4095));
            do_req(t0);
            set_done_after($urandom_range(2, 10), dc);
            wait_valid(vc);
            chk("rnd_latency", vc - dc, 11);
            ack_after($urandom_range(0, 4), 1'b1);
        end

        // Scenario 6: engine never reports done.
        do_req(t0);
`ifdef ARGMAX_TIMEOUT_EN
        wait_valid(vc);
        chk("t6_err",     bus.res_err, 1);
        chk("t6_class",   bus.res_class, 0);
        chk("t6_score",   bus.res_score, 0);
        chk("t6_latency", vc - t0, 3 + TO);
        ack_after(0, 1'b1);
`else
        repeat (100) @(negedge clk);
        chk("t6_busy_held", bus.busy, 1);
        chk("t6_no_valid",  bus.res_valid, 0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
`endif
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
